// File: rtl/msg_pkg.sv
// Shared types for the message editor.
//   MSG_LEN / CHAR_W : message geometry (16 characters of 4 bits)
//   char_t           : one character
//   msg_t            : whole message, packed {m15..m0}, m0 in bits [3:0]
//   rep_state_t      : auto-repeat state encoding
package msg_pkg;

   localparam int MSG_LEN = 16;
   localparam int CHAR_W  = 4;

   typedef logic [CHAR_W-1:0]              char_t;
   typedef logic [MSG_LEN-1:0][CHAR_W-1:0] msg_t;

   typedef enum logic [1:0] {
      REP_IDLE   = 2'd0,
      REP_DELAY  = 2'd1,
      REP_REPEAT = 2'd2
   } rep_state_t;

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button conditioner: 2-FF synchroniser, debounce timer and
// rising-edge detector.
//   clk    : display clock
//   reset  : asynchronous, active-high
//   raw    : unsynchronised button input
//   level  : debounced button level
//   press  : one-cycle strobe in the first cycle that level is high
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level_d;
   logic [CW-1:0] cnt;

   // The timer counts down while the synchronised input disagrees with the
   // accepted level; DEBOUNCE_CYCLES consecutive disagreeing cycles flip it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= RELOAD;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_d <= level;
         if (sync2 == level) begin
            cnt <= RELOAD;
         end else if (cnt == '0) begin
            level <= sync2;
            cnt   <= RELOAD;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign press = level & ~level_d;

endmodule

// File: rtl/message_editor.sv
// Push-button message editor. Edits a 16 x 4-bit shadow buffer and publishes
// it to the live message bus on commit.
//   clk          : display clock
//   reset        : asynchronous, active-high
//   btn_next     : raw button, advance cursor
//   btn_inc      : raw button, increment character at cursor
//   btn_commit   : raw button, copy shadow to live
//   message      : live buffer {m15..m0}
//   cursor       : index of character being edited
//   edit_char    : shadow character at cursor
//   dirty        : shadow edited since last commit
//   commit_pulse : one-cycle strobe aligned with a new message
// Build option: MSG_EDITOR_AUTOREPEAT_EN enables auto-repeat on a held inc.
//
// Repeat FSM:
//   state      | meaning
//   REP_IDLE   | inc not held, or repeat not yet armed
//   REP_DELAY  | inc held, waiting REPEAT_DELAY before first repeat
//   REP_REPEAT | inc held, one repeat every REPEAT_PERIOD cycles
module message_editor
   import msg_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 50000,
   parameter int          REPEAT_DELAY    = 2500000,
   parameter int          REPEAT_PERIOD   = 1000000,
   parameter logic [63:0] INIT_MSG        = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_next,
   input  logic        btn_inc,
   input  logic        btn_commit,
   output logic [63:0] message,
   output logic [3:0]  cursor,
   output logic [3:0]  edit_char,
   output logic        dirty,
   output logic        commit_pulse
);

   logic next_level,   next_press;
   logic inc_level,    inc_press;
   logic commit_level, commit_press;
   logic rep_pulse;

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
      .clk(clk), .reset(reset), .raw(btn_next),
      .level(next_level), .press(next_press)
   );

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
      .clk(clk), .reset(reset), .raw(btn_inc),
      .level(inc_level), .press(inc_press)
   );

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit (
      .clk(clk), .reset(reset), .raw(btn_commit),
      .level(commit_level), .press(commit_press)
   );

   logic unused_levels;
   assign unused_levels = next_level ^ commit_level;

`ifdef MSG_EDITOR_AUTOREPEAT_EN
   localparam int DW = $clog2(REPEAT_DELAY) + 1;
   localparam int PW = $clog2(REPEAT_PERIOD) + 1;
   // The FSM is armed on the edge that ends the press cycle and rep_pulse is
   // registered, so loading DELAY-2 lands the first repeat REPEAT_DELAY
   // cycles after the press pulse.
   localparam logic [DW-1:0] DELAY_LOAD  = DW'(REPEAT_DELAY - 2);
   localparam logic [PW-1:0] PERIOD_LOAD = PW'(REPEAT_PERIOD - 1);

   rep_state_t    rep_state;
   logic [DW-1:0] delay_cnt;
   logic [PW-1:0] period_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rep_state  <= REP_IDLE;
         delay_cnt  <= '0;
         period_cnt <= '0;
         rep_pulse  <= 1'b0;
      end else begin
         rep_pulse <= 1'b0;
         if (!inc_level) begin
            rep_state  <= REP_IDLE;
            delay_cnt  <= '0;
            period_cnt <= '0;
         end else begin
            case (rep_state)
               REP_IDLE: begin
                  if (inc_press) begin
                     rep_state <= REP_DELAY;
                     delay_cnt <= DELAY_LOAD;
                  end
               end
               REP_DELAY: begin
                  if (delay_cnt == '0) begin
                     rep_pulse  <= 1'b1;
                     rep_state  <= REP_REPEAT;
                     period_cnt <= PERIOD_LOAD;
                  end else begin
                     delay_cnt <= delay_cnt - 1'b1;
                  end
               end
               REP_REPEAT: begin
                  if (period_cnt == '0) begin
                     rep_pulse  <= 1'b1;
                     period_cnt <= PERIOD_LOAD;
                  end else begin
                     period_cnt <= period_cnt - 1'b1;
                  end
               end
               default: rep_state <= REP_IDLE;
            endcase
         end
      end
   end
`else
   logic unused_inc_level;
   assign unused_inc_level = inc_level;
   assign rep_pulse        = 1'b0;
`endif

   msg_t live;
   msg_t shadow;

   // One action per cycle; lower-priority strobes in the same cycle are lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         live         <= msg_t'(INIT_MSG);
         shadow       <= msg_t'(INIT_MSG);
         cursor       <= 4'd0;
         dirty        <= 1'b0;
         commit_pulse <= 1'b0;
      end else begin
         commit_pulse <= 1'b0;
         if (commit_press) begin
            live         <= shadow;
            dirty        <= 1'b0;
            commit_pulse <= 1'b1;
         end else if (next_press) begin
            cursor <= cursor + 4'd1;
         end else if (inc_press || rep_pulse) begin
            shadow[cursor] <= shadow[cursor] + char_t'(1);
            dirty          <= 1'b1;
         end
      end
   end

   assign message   = live;
   assign edit_char = shadow[cursor];

endmodule
